// File: rtl/mmul_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : mmul_host_seq
// Brief    : Host-side sequencer for the word-serial modular-multiplier
//            engine. Streams operands A, B and (optionally) P into the engine,
//            pulses start, waits for ready with a timeout, and unloads the
//            result C onto a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module mmul_host_seq #(
    parameter int DW    = 16,
    parameter int WORDS = 16,
    parameter int TMO   = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          keep_p,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] mm_datain,
    output logic          mm_loada,
    output logic          mm_loadb,
    output logic          mm_loadp,
    output logic          mm_en,
    input  logic          mm_rdy,
    output logic          mm_outc,
    input  logic [DW-1:0] mm_regcout,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int c_wcnt_w = $clog2(WORDS) + 1;
    localparam int c_tcnt_w = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [c_wcnt_w-1:0] c_wlast = c_wcnt_w'(WORDS - 1);
    localparam logic [c_tcnt_w-1:0] c_tlast = c_tcnt_w'(TMO - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_LOAD_P = 4'd3,
        S_START  = 4'd4,
        S_ARM    = 4'd5,
        S_WAIT   = 4'd6,
        S_UNLOAD = 4'd7,
        S_FIN    = 4'd8
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_keep_p;
    logic [c_wcnt_w-1:0]   r_wcnt;
    logic [c_tcnt_w-1:0]   r_tcnt;
    logic                  w_load;
    logic                  w_xfer;
    logic                  w_wlast;
    logic                  w_timeout;

    // A word moves either into the engine (load states) or out of it (unload)
    assign w_load    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) ||
                       (r_state == S_LOAD_P);
    assign w_xfer    = (w_load && in_valid) || ((r_state == S_UNLOAD) && out_ready);
    assign w_wlast   = w_xfer && (r_wcnt == c_wlast);
    assign w_timeout = (r_state == S_WAIT) && !mm_rdy && (r_tcnt == c_tlast);
    assign busy      = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Word counter shared by all load phases and the unload phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (w_xfer) begin
            r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
        end
    end

    // Ready-wait timeout counter; cleared in ARM so each wait starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state == S_ARM) begin
            r_tcnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // keep_p is captured only when a start is actually accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keep_p <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_keep_p <= keep_p;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mm_datain   = '0;
        mm_loada    = 1'b0;
        mm_loadb    = 1'b0;
        mm_loadp    = 1'b0;
        mm_en       = 1'b0;
        mm_outc     = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD_A;
            end
            S_LOAD_A: begin
                in_ready  = 1'b1;
                mm_datain = in_data;
                mm_loada  = in_valid;
                if (w_wlast) w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                in_ready  = 1'b1;
                mm_datain = in_data;
                mm_loadb  = in_valid;
                if (w_wlast) w_state_nxt = r_keep_p ? S_START : S_LOAD_P;
            end
            S_LOAD_P: begin
                in_ready  = 1'b1;
                mm_datain = in_data;
                mm_loadp  = in_valid;
                if (w_wlast) w_state_nxt = S_START;
            end
            S_START: begin
                mm_en       = 1'b1;
                w_state_nxt = S_ARM;
            end
            S_ARM: begin
                // Ready is ignored here: it may still be high from the last op
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mm_rdy) begin
                    w_state_nxt = S_UNLOAD;
                end else if (w_timeout) begin
                    err         = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                out_data  = mm_regcout;
                mm_outc   = out_ready;
                if (w_wlast) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mmul_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmul_host_seq
// Brief    : Self-checking bench for mmul_host_seq with an engine model,
//            operand source and result sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmul_host_seq;
    localparam int DW  = 16;
    localparam int W   = 16;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          keep_p = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] mm_datain;
    logic          mm_loada, mm_loadb, mm_loadp, mm_en, mm_outc;
    logic          mm_rdy = 1'b0;
    logic [DW-1:0] mm_regcout = '0;
    logic          busy, done, err;

    mmul_host_seq #(.DW(DW), .WORDS(W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .keep_p(keep_p),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mm_datain(mm_datain), .mm_loada(mm_loada), .mm_loadb(mm_loadb),
        .mm_loadp(mm_loadp), .mm_en(mm_en), .mm_rdy(mm_rdy), .mm_outc(mm_outc),
        .mm_regcout(mm_regcout), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Engine result function: any fixed mapping of the loaded words will do
    function automatic logic [15:0] cfun(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] p, input int i);
        return (a ^ {b[7:0], b[15:8]}) + p + 16'(i);
    endfunction

    // ---------------- operand source ----------------
    logic [15:0] src[3*W];
    logic [15:0] cur_p[W];
    int  src_idx = 0, src_n = 0;
    bit  tog_b = 0, phase = 0, hs_in = 0;
    initial forever begin
        @(negedge clk);
        hs_in = in_valid && in_ready;
        @(posedge clk); #1;
        if (hs_in) src_idx++;
        phase    = !phase;
        in_valid = (src_idx < src_n) && !(tog_b && src_idx >= W && src_idx < 2*W && phase);
        in_data  = (src_idx < src_n) ? src[src_idx] : 16'h0;
    end

    // ---------------- result sink ----------------
    bit stall_req = 0, stall_used = 0, hs_out = 0;
    int n_hs = 0, stall_left = 0;
    initial forever begin
        @(negedge clk);
        hs_out = out_valid && out_ready;
        @(posedge clk); #1;
        if (hs_out) n_hs++;
        if (stall_req && n_hs == 8 && !stall_used) begin
            stall_left = 5;
            stall_used = 1;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    end

    // ---------------- engine model ----------------
    logic [15:0] eng_a[$], eng_b[$], eng_p[$];
    logic [15:0] eng_c[W];
    int  c_idx = W, rdy_cnt = -1, rdy_delay = 50, rdy_rise_cyc = -1;
    bit  stale = 0, drop_pend = 0;
    bit  s_a, s_b, s_p, s_en, s_c;
    logic [15:0] s_d;
    initial forever begin
        @(negedge clk);
        s_a = mm_loada; s_b = mm_loadb; s_p = mm_loadp;
        s_en = mm_en; s_c = mm_outc; s_d = mm_datain;
        @(posedge clk); #1;
        if (s_a) begin eng_a.push_back(s_d); if (eng_a.size() > W) void'(eng_a.pop_front()); end
        if (s_b) begin eng_b.push_back(s_d); if (eng_b.size() > W) void'(eng_b.pop_front()); end
        if (s_p) begin eng_p.push_back(s_d); if (eng_p.size() > W) void'(eng_p.pop_front()); end
        if (drop_pend) begin mm_rdy = 1'b0; drop_pend = 0; end
        if (s_en) begin
            for (int i = 0; i < W; i++)
                eng_c[i] = (i < eng_a.size() && i < eng_b.size() && i < eng_p.size()) ?
                           cfun(eng_a[i], eng_b[i], eng_p[i], i) : 16'h0;
            c_idx = 0;
            if (stale) drop_pend = 1; else mm_rdy = 1'b0;
            rdy_cnt = rdy_delay;
        end
        if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) begin mm_rdy = 1'b1; rdy_rise_cyc = cyc; rdy_cnt = -1; end
        end
        if (s_c && c_idx < W) c_idx++;
        mm_regcout = (c_idx < W) ? eng_c[c_idx] : 16'h0;
    end

    // ---------------- per-cycle compare and transaction record ----------------
    logic [15:0] op_a[$], op_b[$], op_p[$], op_out[$];
    int  n_en, n_done, n_err, en_cyc, first_ov_cyc, last_hs_cyc, last_in_cyc, done_cyc, err_cyc;
    bit  busy_m = 0, prev_ov = 0, prev_or = 0;
    logic [15:0] prev_od = '0;
    always @(negedge clk) begin
        if (rst) begin
            busy_m  = 0;
            prev_ov = 0;
        end else begin
            chk("busy", 32'(busy), 32'(busy_m));
            chk("strobe_onehot", 32'($countones({mm_loada, mm_loadb, mm_loadp, mm_outc, mm_en}) <= 1), 32'd1);
            if (in_valid && in_ready) begin
                chk("load_strobe", 32'($countones({mm_loada, mm_loadb, mm_loadp})), 32'd1);
                chk("datain", 32'(mm_datain), 32'(in_data));
            end else begin
                chk("no_load", 32'({mm_loada, mm_loadb, mm_loadp}), 32'd0);
            end
            chk("outc", 32'(mm_outc), 32'(out_valid && out_ready));
            chk("rdy_and_valid", 32'(in_ready && out_valid), 32'd0);
            if (out_valid) chk("out_data", 32'(out_data), 32'(mm_regcout));
            if (out_valid && prev_ov && !prev_or) chk("out_hold", 32'(out_data), 32'(prev_od));
            if (mm_loada) op_a.push_back(mm_datain);
            if (mm_loadb) op_b.push_back(mm_datain);
            if (mm_loadp) op_p.push_back(mm_datain);
            if (mm_loada || mm_loadb || mm_loadp) last_in_cyc = cyc;
            if (mm_en) begin n_en++; if (en_cyc < 0) en_cyc = cyc; end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid && out_ready) begin op_out.push_back(out_data); last_hs_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            if (err) begin n_err++; err_cyc = cyc; end
            prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
            if (done || err) busy_m = 0;
            else if (start && !busy_m) busy_m = 1;
        end
    end

    int start_cyc;

    task automatic check_idle_outputs(input string nm);
        chk(nm, 32'({busy, in_ready, out_valid, mm_en, mm_loada, mm_loadb, mm_loadp,
                     mm_outc, done, err}), 32'd0);
        chk({nm, "_data"}, 32'({mm_datain, out_data}), 32'd0);
    endtask

    // One operation: prepare stimulus, start, wait, then check the record
    task automatic run_op(input bit keep, input bit tog, input bit stall, input bit stale_i,
                          input bit extra_start, input int delay, input bit exp_err,
                          input bit fixed, input bit abort);
        int k;
        int mism;
        for (int i = 0; i < W; i++) begin
            src[i]   = fixed ? 16'h1100 + 16'(i) : 16'($urandom);
            src[W+i] = fixed ? 16'h2200 + 16'(i) : 16'($urandom);
            if (!keep) begin
                src[2*W+i] = fixed ? 16'h0003 + 16'(i) : 16'($urandom);
                cur_p[i]   = src[2*W+i];
            end
        end
        src_n = keep ? 2*W : 3*W;
        src_idx = 0; tog_b = tog;
        stall_req = stall; stall_used = 0; n_hs = 0;
        stale = stale_i; rdy_delay = delay;
        op_a.delete(); op_b.delete(); op_p.delete(); op_out.delete();
        n_en = 0; n_done = 0; n_err = 0; en_cyc = -1; first_ov_cyc = -1;
        last_hs_cyc = -1; last_in_cyc = -1; done_cyc = -1; err_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1; keep_p = keep; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; keep_p = 1'b0;
        if (abort) begin
            k = 0;
            while (op_b.size() < 5 && k < 200) begin @(posedge clk); #1; k++; end
            chk("abort_reach_b", 32'(k < 200), 32'd1);
            @(posedge clk); #3;
            rst = 1'b1;
            #1;
            check_idle_outputs("rst_async");
            @(posedge clk); @(posedge clk); #3;
            rst = 1'b0;
            return;
        end
        k = 0;
        while (n_done + n_err == 0 && k < 3000) begin
            @(posedge clk); #1; k++;
            if (extra_start) start = (k == 20);
        end
        start = 1'b0;
        chk("op_finish", 32'(k < 3000), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_fall", 32'(busy), 32'd0);
        chk("a_count", 32'(op_a.size()), 32'(W));
        chk("b_count", 32'(op_b.size()), 32'(W));
        chk("p_count", 32'(op_p.size()), keep ? 32'd0 : 32'(W));
        mism = 0;
        for (int i = 0; i < W; i++) begin
            if (i >= op_a.size() || op_a[i] !== src[i]) mism++;
            if (i >= op_b.size() || op_b[i] !== src[W+i]) mism++;
            if (!keep && (i >= op_p.size() || op_p[i] !== src[2*W+i])) mism++;
        end
        chk("load_words", 32'(mism), 32'd0);
        chk("en_count", 32'(n_en), 32'd1);
        chk("en_after_last_load", 32'(en_cyc), 32'(last_in_cyc + 1));
        if (exp_err) begin
            chk("err_count", 32'(n_err), 32'd1);
            chk("no_done", 32'(n_done), 32'd0);
            chk("no_out", 32'(op_out.size()), 32'd0);
        end else begin
            chk("done_count", 32'(n_done), 32'd1);
            chk("no_err", 32'(n_err), 32'd0);
            chk("out_count", 32'(op_out.size()), 32'(W));
            mism = 0;
            for (int i = 0; i < W; i++)
                if (i >= op_out.size() || op_out[i] !== cfun(src[i], src[W+i], cur_p[i], i)) mism++;
            chk("c_words", 32'(mism), 32'd0);
            chk("done_after_last_hs", 32'(done_cyc), 32'(last_hs_cyc + 1));
            chk("unload_after_rdy", 32'(first_ov_cyc), 32'(rdy_rise_cyc + 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_idle_outputs("reset_state");

        // nominal op with fixed operands
        run_op(0, 0, 0, 0, 0, 50, 0, 1, 0);
        chk("lat_start_en", 32'(en_cyc - start_cyc), 32'd49);
        chk("first_c_word", 32'((op_out.size() > 0) ? op_out[0] : 16'h0), 32'h1125);

        // reuse modulus
        run_op(1, 0, 0, 0, 0, 20, 0, 0, 0);
        chk("lat_keep_p", 32'(en_cyc - start_cyc), 32'd33);

        // gapped B stream plus a start while busy
        run_op(0, 1, 0, 0, 1, 20, 0, 0, 0);

        // downstream back-pressure mid-unload
        run_op(0, 0, 1, 0, 0, 10, 0, 0, 0);

        // ready still high from previous op during ARM
        run_op(0, 0, 0, 1, 0, 30, 0, 0, 0);
        chk("stale_rdy_unload", 32'(first_ov_cyc - en_cyc), 32'd31);

        // engine never answers
        run_op(0, 0, 0, 0, 0, -1, 1, 0, 0);
        chk("err_cycle", 32'(err_cyc - en_cyc), 32'd65);

        // recovery after timeout
        run_op(0, 0, 0, 0, 0, 15, 0, 0, 0);

        // reset in LOAD_B, then a clean restart
        run_op(0, 0, 0, 0, 0, 15, 0, 0, 1);
        run_op(0, 0, 0, 0, 0, 12, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mmul_host_seq.md
Name: mmul_host_seq

Overview:
- Host-side sequencer that drives the modular-multiplier engine's word-serial operand/result interface.
- Pulls operand words A, B and P from an upstream valid/ready stream and strobes them into the engine with the load strobes. It then pulses the engine enable, waits for engine ready, and unloads result C word-by-word onto a downstream valid/ready stream.
- It is the initiator end of the engine's load/start/ready/unload protocol.

Parameters:
- DW, 16, data word width; equals the engine datain/regcout width.
- WORDS, 16, words per operand and per result (256-bit operands at the defaults).
- TMO, 4096, maximum cycles spent waiting for engine ready before the error exit.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin an operation; sampled in IDLE only
- keep_p  in  1  sampled with start; 1 skips the P load and reuses the modulus already in the engine
- in_data  in  DW  operand word stream: A[0..WORDS-1], then B, then P; least-significant word first
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid & in_ready
- out_data  out  DW  result word; driven combinationally from mm_regcout
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the result word
- mm_datain  out  DW  to engine datain
- mm_loada, mm_loadb, mm_loadp  out  1  engine register load strobes; one word shifted per cycle while high
- mm_en  out  1  engine start pulse
- mm_rdy  in  1  engine done level
- mm_outc  out  1  engine C-register unload strobe; one word shifted per cycle while high
- mm_regcout  in  DW  engine C output word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on ready timeout

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0, state goes to IDLE, and word and timeout counters clear. Reset mid-operation aborts with no done or err pulse.
- States and transitions:
  - IDLE -> LOAD_A on start.
  - LOAD_A -> LOAD_B.
  - LOAD_B -> LOAD_P, or -> START if keep_p was latched as 1.
  - LOAD_P -> START.
  - START -> ARM -> WAIT.
  - WAIT -> UNLOAD, or -> IDLE on timeout.
  - UNLOAD -> FIN -> IDLE.
- Load states:
  - in_ready = 1.
  - mm_datain = in_data.
  - The strobe matching the state (mm_loada, mm_loadb or mm_loadp) = in_valid.
  - Each accepted word increments a word counter (width clog2(WORDS)+1).
  - On the WORDS-th accepted word the counter clears and the state advances next cycle.
  - in_valid low stalls with the strobe low; the engine does not shift.
- No strobe is ever asserted outside its state, and at most one engine strobe is high per cycle.
- START: mm_en = 1 for exactly one cycle.
- ARM: one cycle in which mm_rdy is ignored, so a stale ready level from the previous operation is not taken as completion. The timeout counter clears.
- WAIT:
  - Timeout counter increments each cycle.
  - mm_rdy = 1 -> UNLOAD.
  - Counter reaching TMO-1 with mm_rdy still 0 -> err pulse, then IDLE.
  - mm_rdy = 1 takes priority in the same cycle.
- UNLOAD:
  - out_valid = 1.
  - out_data = mm_regcout.
  - mm_outc = out_ready, so the engine shifts only on a handshake.
  - Word counter counts handshakes.
  - After the WORDS-th handshake -> FIN.
  - Word order out equals engine shift order (LSW first).
- FIN: done = 1 for one cycle, then IDLE.
- start asserted while busy is ignored. keep_p is latched only on an accepted start.
- in_ready = 0 outside the load states; out_valid = 0 outside UNLOAD.
- Latency with no stalls and keep_p = 0: start to first mm_en = 3·WORDS + 1 cycles; last result handshake to done = 1 cycle.

Test Plan:
- WORDS=16, keep_p=0, in_valid always 1, engine model asserts rdy 50 cycles after en -> exactly 16 loada, 16 loadb, 16 loadp cycles with in_data passed through; mm_en high only at cycle 49 after start; 16 out handshakes equal to the model's C words in order; done one cycle after the last handshake.
- keep_p=1 -> mm_loadp never asserts; mm_en follows the 32nd accepted word by one cycle; no P words consumed.
- in_valid toggling 1,0,1,0 during LOAD_B -> mm_loadb high only on valid cycles; exactly 16 B words loaded.
- out_ready low for 5 cycles mid-unload -> mm_outc low for those cycles; out_data held; total of 16 unloaded words, none lost or duplicated.
- mm_rdy held at 1 from the previous operation, new op with the model asserting rdy at cycle 30 -> UNLOAD entered only after the model's rdy; no early exit on the stale level.
- TMO=64, model never asserts rdy -> err pulse at cycle 63 of WAIT, no done; busy falls; a subsequent start is accepted.
- rst asserted during LOAD_B -> all outputs 0 immediately (asynchronous); a following start restarts at LOAD_A with the word count at 0.
